// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared frontend entry type and exception codes
package fetch_queue_pkg;

  localparam logic [7:0] EXC_NONE          = 8'h00;
  localparam logic [7:0] EXC_MISALIGNED_PC = 8'h84;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] slot;
    logic [31:0] instr;
    logic [7:0]  exc;
  } fq_entry_t;

  function automatic logic is_excepting(input fq_entry_t e);
    return e.exc != EXC_NONE;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch arrival, credit and dual-dequeue bundle of the fetch queue
interface fetch_queue_if;

  logic        fetch_issue;
  logic        issue_accept;
  logic        bubble_in;
  logic [31:0] pc_in;
  logic [31:0] slot_id_in;
  logic [7:0]  exc_in;
  logic [31:0] instr_in;

  logic        deq0_valid;
  logic [31:0] deq0_pc;
  logic [31:0] deq0_slot;
  logic [31:0] deq0_instr;
  logic [7:0]  deq0_exc;
  logic        deq1_valid;
  logic [31:0] deq1_pc;
  logic [31:0] deq1_slot;
  logic [31:0] deq1_instr;
  logic [7:0]  deq1_exc;
  logic [1:0]  deq_count;

  modport master (
    output fetch_issue, bubble_in, pc_in, slot_id_in, exc_in, instr_in, deq_count,
    input  issue_accept,
    input  deq0_valid, deq0_pc, deq0_slot, deq0_instr, deq0_exc,
    input  deq1_valid, deq1_pc, deq1_slot, deq1_instr, deq1_exc
  );

  modport slave (
    input  fetch_issue, bubble_in, pc_in, slot_id_in, exc_in, instr_in, deq_count,
    output issue_accept,
    output deq0_valid, deq0_pc, deq0_slot, deq0_instr, deq0_exc,
    output deq1_valid, deq1_pc, deq1_slot, deq1_instr, deq1_exc
  );

endinterface

// File: rtl/fetch_queue_credit.sv
// rtl/fetch_queue_credit.sv - in-flight fetch counter and issue_accept credit generation
module fetch_queue_credit #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          flush,
  input  logic          fetch_issue,
  input  logic          arrival,
  input  logic [CW-1:0] count,
  output logic          issue_accept
);

  logic [CW-1:0] inflight;
  logic [CW:0]   used;

  // Registered state only: fetch_issue must never feed back into issue_accept.
  assign used         = {1'b0, count} + {1'b0, inflight};
  assign issue_accept = used < (CW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (clk_en) begin
      if (flush) begin
        inflight <= '0;
      end else if (fetch_issue && !arrival) begin
        if (inflight != CW'(DEPTH)) inflight <= inflight + CW'(1);
      end else if (arrival && !fetch_issue) begin
        // An arrival with nothing outstanding is a protocol violation; hold at zero.
        if (inflight != '0) inflight <= inflight - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - decode-side fetch queue, dual in-order dequeue with credit-based issue
// Optional FETCH_QUEUE_SLOT_CHECK_EN adds a sticky slot_err for non-consecutive arrival slot ids.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         flush,
  fetch_queue_if.slave fq,
  output logic         overflow_err
`ifdef FETCH_QUEUE_SLOT_CHECK_EN
  ,
  output logic         slot_err
`endif
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t     mem [DEPTH];
  fq_entry_t     e0, e1;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1;
  logic [CW-1:0] count;
  logic          arrival, full, wr_en;
  logic [1:0]    n_valid, deq_eff;

  assign arrival = !fq.bubble_in;
  assign rd_ptr1 = rd_ptr + PW'(1);
  assign e0      = mem[rd_ptr];
  assign e1      = mem[rd_ptr1];

  assign fq.deq0_valid = count != '0;
  assign fq.deq1_valid = (count >= CW'(2)) && !is_excepting(e0) && !is_excepting(e1);
  assign fq.deq0_pc    = e0.pc;
  assign fq.deq0_slot  = e0.slot;
  assign fq.deq0_instr = e0.instr;
  assign fq.deq0_exc   = e0.exc;
  assign fq.deq1_pc    = e1.pc;
  assign fq.deq1_slot  = e1.slot;
  assign fq.deq1_instr = e1.instr;
  assign fq.deq1_exc   = e1.exc;

  assign n_valid = {1'b0, fq.deq0_valid} + {1'b0, fq.deq1_valid};
  assign deq_eff = (fq.deq_count < n_valid) ? fq.deq_count : n_valid;
  assign full    = count == CW'(DEPTH);
  // When full, a same-cycle dequeue frees the head slot that wr_ptr points at.
  assign wr_en   = arrival && !(full && deq_eff == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        else if (arrival) overflow_err <= 1'b1;
        rd_ptr <= rd_ptr + PW'(deq_eff);
        count  <= count + CW'(wr_en) - CW'(deq_eff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && clk_en && !flush && wr_en)
      mem[wr_ptr] <= '{pc: fq.pc_in, slot: fq.slot_id_in, instr: fq.instr_in, exc: fq.exc_in};
  end

  fetch_queue_credit #(.DEPTH(DEPTH)) u_credit (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .flush        (flush),
    .fetch_issue  (fq.fetch_issue),
    .arrival      (arrival),
    .count        (count),
    .issue_accept (fq.issue_accept)
  );

`ifdef FETCH_QUEUE_SLOT_CHECK_EN
  logic [31:0] expected_slot;
  logic        slot_seen;

  // First arrival after reset or flush seeds the sequence; later ones must follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_seen     <= 1'b0;
      expected_slot <= '0;
      slot_err      <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        slot_seen <= 1'b0;
      end else if (arrival) begin
        slot_seen     <= 1'b1;
        expected_slot <= slot_seen ? expected_slot + 32'd1 : fq.slot_id_in + 32'd1;
        if (slot_seen && fq.slot_id_in != expected_slot) slot_err <= 1'b1;
      end
    end
  end
`endif

endmodule
